spm_ctrl: RTL and testbench
===========================

Name: spm_ctrl

Overview:
Sequencer for the serial-parallel multiplier (spm) carry-save array.
- Accepts a multiplicand/multiplier pair on a start handshake and clears the CSA chain.
- Presents the multiplicand in parallel and streams the multiplier LSB-first.
- Collects the serial product into a 2*WIDTH register and signals completion.
- Sits between the host logic and the spm datapath; it is the only driver of the spm inputs.

Parameters:
WIDTH, 32, multiplicand/multiplier width in bits; spm array length.
PLAT, 1, cycles from a y bit presented on spm_y to the matching product bit on spm_p (1..4).

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
mc  input  WIDTH  multiplicand; captured when start is accepted.
mp  input  WIDTH  multiplier; captured when start is accepted.
busy  output  1  high from the accepting edge until DONE is left.
done  output  1  one-cycle pulse: prod is valid.
prod  output  2*WIDTH  product; held stable until the next accepted start.
spm_x  output  WIDTH  parallel multiplicand to the array.
spm_y  output  1  serial multiplier bit to the array.
spm_clr  output  1  synchronous clear of the CSA carry/sum state.
spm_p  input  1  serial product bit from the array.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, prod=0, spm_x=0, spm_y=0, spm_clr=0, counter=0, mp shadow=0. An aborted run leaves no partial prod.
- All outputs are registered.

FSM states: IDLE, CLR, RUN, DONE.
- IDLE:
  - On start=1: capture mc into spm_x and mp into the shadow shift register, then go to CLR.
  - busy rises on the same edge.
- CLR:
  - Exactly one cycle. spm_clr=1, spm_y=0, counter=0. Next state is RUN.
- RUN lasts N = 2*WIDTH+PLAT cycles, indexed i = 0..N-1 by the counter:
  - spm_y = shadow[i] for i < WIDTH, 0 for WIDTH <= i < 2*WIDTH, 0 for i >= 2*WIDTH.
  - For PLAT <= i < PLAT+2*WIDTH: prod <= {spm_p, prod[2*WIDTH-1:1]}, i.e. LSB-first shift-in.
  - prod is cleared on the CLR edge.
  - At i = N-1, go to DONE.
- DONE:
  - One cycle. done=1, busy=1. Next state is IDLE, where busy=0.
- Latency: done is high in the cycle after edge 2*WIDTH+PLAT+1, counting the start-accepting edge as edge 0.
- start is ignored while busy=1, including in the DONE cycle. Back-to-back throughput is one op per N+3 cycles.
- spm_x is held constant from CLR through DONE. spm_y is 0 outside RUN.
- Counter width is clog2(N+1). It never wraps within a run.
- Unsigned arithmetic: prod = mc*mp, exact, 2*WIDTH bits, no truncation.

Optional Feature:
SPM_SIGNED_EN
- Defined:
  - During RUN cycles WIDTH <= i < 2*WIDTH, spm_y = shadow[WIDTH-1], which sign-extends the multiplier.
  - prod = signed(mc)*signed(mp) in two's complement, 2*WIDTH bits.
  - The array itself is assumed signed-capable (Baugh-Wooley top cell).
- Undefined:
  - Zero extension as in the unsigned behaviour above. No other behavioural difference; port list is identical.

Test Plan:
1. WIDTH=8, PLAT=1, behavioural spm model: mc=3, mp=5, start 1 cycle -> busy rises on the next edge; spm_clr high for exactly 1 cycle; done pulses 18 edges after acceptance; prod=16'h000F.
2. mc=8'hFF, mp=8'hFF -> prod=16'hFE01. mc=0, mp=8'hA5 -> prod=0. Each done is a single-cycle pulse.
3. start held high continuously for 3 ops (mc=7, mp=9) -> exactly one op per 20 cycles; start ignored while busy; prod=63 stays stable between dones.
4. Assert rst asynchronously mid-RUN (i=5), between clock edges -> all outputs 0 immediately. A new start after release gives a correct result: mc=2, mp=3 -> prod=6.
5. SPM_SIGNED_EN defined: mc=8'hFD (-3), mp=5 -> prod=16'hFFF1. Then mc=8'h80, mp=8'h80 -> prod=16'h4000. Undefined, same vectors -> 16'h04F1 and 16'h4000.
6. PLAT=3 sweep, random 1000 pairs against a reference multiply -> all match; done latency is 2*WIDTH+PLAT+1 edges for every op.

Source files
------------

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for the serial-parallel multiplier (spm) carry-save array.
//
// Accepts an operand pair on start, clears the CSA chain for one cycle, holds
// the multiplicand on spm_x, streams the multiplier LSB-first on spm_y
// (zero- or sign-extended to 2*WIDTH bits) and shifts the serial product from
// spm_p into prod, LSB first. done pulses for one cycle when prod is complete.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, mc, mp     request and operands, sampled only in IDLE
//   busy, done, prod  status and 2*WIDTH-bit product (held until next start)
//   spm_x, spm_y      parallel multiplicand / serial multiplier to the array
//   spm_clr           synchronous clear of the array carry/sum state
//   spm_p             serial product bit from the array
//
// Parameters: WIDTH (operand width), PLAT (spm_y -> spm_p latency, 1..4).
// Build option: define SPM_SIGNED_EN for two's-complement multiplication
// (multiplier sign-extended over the upper WIDTH stream bits).
// All outputs are registered.

module spm_ctrl #(
    parameter int WIDTH = 32,
    parameter int PLAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    output logic               spm_clr,
    input  logic               spm_p
);

    localparam int N  = 2 * WIDTH + PLAT;  // RUN length in cycles
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     shadow_q, shadow_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic                 y_q, y_d;
    logic                 clr_q, clr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    // Multiplier stream bit for RUN index i (extension bits past WIDTH).
    function automatic logic y_bit(input logic [WIDTH-1:0] sh, input int i);
        logic [WIDTH-1:0] t;
        t = sh >> i;
        if (i < WIDTH) return t[0];
`ifdef SPM_SIGNED_EN
        if (i < 2 * WIDTH) return sh[WIDTH-1];
`endif
        return 1'b0;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        x_d      = x_q;
        busy_d   = busy_q;
        prod_d   = prod_q;
        y_d      = 1'b0;
        clr_d    = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = mc;
                    shadow_d = mp;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    clr_d    = 1'b1;      // spm_clr high during the CLR cycle
                    prod_d   = '0;        // no stale product survives a new run
                    state_d  = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                y_d     = y_bit(shadow_q, 0);  // first bit presented in RUN i=0
                state_d = RUN;
            end
            RUN: begin
                // Product bit for y index j arrives PLAT cycles later.
                if (int'(cnt_q) >= PLAT && int'(cnt_q) < PLAT + 2 * WIDTH)
                    prod_d = {spm_p, prod_q[2*WIDTH-1:1]};
                if (int'(cnt_q) == N - 1) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // spm_y is registered, so look one index ahead.
                    y_d   = y_bit(shadow_q, int'(cnt_q) + 1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            x_q      <= '0;
            y_q      <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            prod_q   <= prod_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign prod    = prod_q;
    assign spm_x   = x_q;
    assign spm_y   = y_q;
    assign spm_clr = clr_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: two instances (PLAT=1 and PLAT=3, WIDTH=8) share the
// host stimulus; each drives its own behavioural spm array model. A timeline
// model per instance predicts busy/done/spm_clr/spm_y/prod from the
// acceptance edge; products come from a plain reference multiply.
module tb_spm_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] mc = '0, mp = '0;

    logic           busy    [2];
    logic           done    [2];
    logic [2*W-1:0] prod    [2];
    logic [W-1:0]   spm_x   [2];
    logic           spm_y   [2];
    logic           spm_clr [2];
    logic           spm_p   [2];

    int n_chk = 0, n_fail = 0;
    int edges = 0;
    int ndone [2];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SPM_SIGNED_EN
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    // Expected multiplier stream bit at RUN index i.
    function automatic logic exp_y(input logic [W-1:0] b, input int i);
        if (i < W) return b[i];
`ifdef SPM_SIGNED_EN
        if (i < 2 * W) return b[W-1];
`endif
        return 1'b0;
    endfunction

    // Array model helpers: accumulate streamed y bits, product bit k.
    function automatic logic [2*W-1:0] yins(input logic [2*W-1:0] acc, input logic b, input int k);
        logic [2*W-1:0] r;
        r = acc;
        if (k < 2 * W) r[k] = b;
        return r;
    endfunction

    function automatic logic pbit(input logic [W-1:0] x, input logic [2*W-1:0] y, input int k);
        logic [2*W-1:0] xe, f;
`ifdef SPM_SIGNED_EN
        xe = {{W{x[W-1]}}, x};
`else
        xe = {{W{1'b0}}, x};
`endif
        f = xe * y;
        return (k < 2 * W) ? f[k] : 1'b0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int P = (g == 0) ? 1 : 3;
        localparam int N = 2 * W + P;

        spm_ctrl #(.WIDTH(W), .PLAT(P)) u_dut (
            .clk(clk), .rst(rst), .start(start), .mc(mc), .mp(mp),
            .busy(busy[g]), .done(done[g]), .prod(prod[g]),
            .spm_x(spm_x[g]), .spm_y(spm_y[g]), .spm_clr(spm_clr[g]),
            .spm_p(spm_p[g])
        );

        // Behavioural serial-parallel array with PLAT cycles of latency.
        logic [2*W-1:0] yacc = '0;
        int             k = 0;
        logic [P:0]     pipe = '0;
        assign spm_p[g] = pipe[P-1];

        always @(posedge clk) begin
            if (spm_clr[g]) begin
                yacc <= '0;
                k    <= 0;
                pipe <= {pipe[P-1:0], 1'b0};
            end else begin
                yacc <= yins(yacc, spm_y[g], k);
                pipe <= {pipe[P-1:0], pbit(spm_x[g], yins(yacc, spm_y[g], k), k)};
                if (k < 2 * W) k <= k + 1;
            end
        end

        // Timeline model: an op occupies edges a .. a+N+1 after acceptance.
        logic           m_act = 1'b0;
        int             m_a = 0;
        logic [W-1:0]   m_mc = '0, m_mp = '0;
        logic [2*W-1:0] m_hold = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_act  <= 1'b0;
                m_hold <= '0;
            end else begin
                if ((!m_act || edges >= m_a + N + 2) && start) begin
                    m_act <= 1'b1;
                    m_a   <= edges + 1;
                    m_mc  <= mc;
                    m_mp  <= mp;
                end
                if (m_act && edges + 1 == m_a + N + 1)
                    m_hold <= ref_mul(m_mc, m_mp);
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("rst_busy%0d", g), 64'(busy[g]), 64'd0);
                chk($sformatf("rst_done%0d", g), 64'(done[g]), 64'd0);
                chk($sformatf("rst_prod%0d", g), 64'(prod[g]), 64'd0);
                chk($sformatf("rst_x%0d", g), 64'(spm_x[g]), 64'd0);
                chk($sformatf("rst_clr%0d", g), 64'(spm_clr[g]), 64'd0);
            end else begin
                int  rel;
                logic in_op;
                rel   = edges - m_a;
                in_op = m_act && rel <= N + 1;
                if (done[g]) ndone[g]++;
                chk($sformatf("busy%0d", g), 64'(busy[g]), 64'(in_op));
                chk($sformatf("done%0d", g), 64'(done[g]), 64'(in_op && rel == N + 1));
                chk($sformatf("clr%0d", g), 64'(spm_clr[g]), 64'(in_op && rel == 0));
                chk($sformatf("y%0d", g), 64'(spm_y[g]),
                    64'((in_op && rel >= 1 && rel <= N) ? exp_y(m_mp, rel - 1) : 1'b0));
                if (in_op)
                    chk($sformatf("x%0d", g), 64'(spm_x[g]), 64'(m_mc));
                if (!in_op || rel == N + 1)
                    chk($sformatf("prod%0d", g), 64'(prod[g]), 64'(m_hold));
            end
        end
    end

    localparam int NMAX = 2 * W + 3;

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        mc = a; mp = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (NMAX + 3) @(negedge clk);
    endtask

    task automatic chk_both(input string tag, input logic [2*W-1:0] exp);
        chk({tag, "_p1"}, 64'(prod[0]), 64'(exp));
        chk({tag, "_p3"}, 64'(prod[1]), 64'(exp));
    endtask

    initial begin
        ndone[0] = 0; ndone[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(8'd3, 8'd5);
        chk_both("p3x5", 16'h000F);
`ifdef SPM_SIGNED_EN
        do_op(8'hFF, 8'hFF);   chk_both("pffxff", 16'h0001);
`else
        do_op(8'hFF, 8'hFF);   chk_both("pffxff", 16'hFE01);
`endif
        do_op(8'h00, 8'hA5);   chk_both("p0xa5", 16'h0000);
`ifdef SPM_SIGNED_EN
        do_op(8'hFD, 8'h05);   chk_both("pfdx5", 16'hFFF1);
`else
        do_op(8'hFD, 8'h05);   chk_both("pfdx5", 16'h04F1);
`endif
        do_op(8'h80, 8'h80);   chk_both("p80x80", 16'h4000);

        // start held high: PLAT=1 instance completes one op per 20 cycles.
        @(negedge clk);
        mc = 8'd7; mp = 8'd9; start = 1'b1;
        ndone[0] = 0; ndone[1] = 0;
        repeat (60) @(negedge clk);
        start = 1'b0;
        chk("held_ndone_p1", 64'(ndone[0]), 64'd3);
        chk("held_ndone_p3", 64'(ndone[1]), 64'd2);
        repeat (30) @(negedge clk);
        chk_both("held_63", 16'd63);

        // Asynchronous reset in the middle of RUN (i = 5).
        @(negedge clk);
        mc = 8'hB7; mp = 8'h6D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("async_busy%0d", g), 64'(busy[g]), 64'd0);
            chk($sformatf("async_prod%0d", g), 64'(prod[g]), 64'd0);
            chk($sformatf("async_y%0d", g), 64'(spm_y[g]), 64'd0);
            chk($sformatf("async_x%0d", g), 64'(spm_x[g]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_op(8'd2, 8'd3);
        chk_both("after_rst", 16'd6);

        // Random operand pairs; the monitors compare every product.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            do_op(a, b);
            if (n % 100 == 0) chk_both("rand", ref_mul(a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
